// File: rtl/oam_dma.sv
// oam_dma: CPU-triggered bus initiator that copies one source page into the OAM window.
// Each byte is a read/capture/write triple; strobes are only driven while the arbiter grants the bus.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] DEST_BASE    = 16'hFE00,
  parameter int          XFER_LEN     = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  output logic [7:0]  cpu_rdata,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] m_addr,
  output logic        m_rd,
  output logic        m_wr,
  output logic [7:0]  m_wdata,
  input  logic [7:0]  m_rdata,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    READ  = 3'd2,
    CAPT  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [7:0] LAST_INDEX = 8'(XFER_LEN - 1);

  state_t      state_r;
  logic [7:0]  index_r;
  logic [7:0]  page_r;
  logic [7:0]  src_page_r;
  logic [7:0]  latch_r;
  logic [15:0] addr_hold_r;
  logic [7:0]  wdata_hold_r;
  logic        bus_req_r;
  logic        busy_r;
  logic        done_r;
  logic [7:0]  cpu_rdata_r;

  logic        trigger_s;
  logic [7:0]  eff_page_s;
  logic        rd_issue_s;
  logic        wr_issue_s;
  logic [15:0] m_addr_s;
  logic [7:0]  m_wdata_s;

  // Trigger decode, source-page clamp and grant-qualified strobes
  always_comb begin
    trigger_s = cpu_wr && (cpu_addr == DMA_REG_ADDR);
    // Pages E0..FF alias the echo region and are folded down by 0x20
    if (cpu_wdata >= 8'hE0) begin
      eff_page_s = cpu_wdata - 8'h20;
    end else begin
      eff_page_s = cpu_wdata;
    end
    rd_issue_s = (state_r == READ) && bus_gnt;
    wr_issue_s = (state_r == WRITE) && bus_gnt;
  end

  // Bus address/data mux; holds the last driven values while no strobe is active
  always_comb begin
    m_addr_s  = addr_hold_r;
    m_wdata_s = wdata_hold_r;
    if (rd_issue_s) begin
      m_addr_s = {src_page_r, 8'h00} + {8'h00, index_r};
    end else if (wr_issue_s) begin
      m_addr_s  = DEST_BASE + {8'h00, index_r};
      m_wdata_s = latch_r;
    end else begin
      m_addr_s  = addr_hold_r;
      m_wdata_s = wdata_hold_r;
    end
  end

  // Hold registers for the bus address and write data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_hold_r  <= 16'h0000;
      wdata_hold_r <= 8'h00;
    end else begin
      addr_hold_r  <= m_addr_s;
      wdata_hold_r <= m_wdata_s;
    end
  end

  // Transfer FSM with registered bus_req/busy/done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      index_r    <= 8'h00;
      page_r     <= 8'h00;
      src_page_r <= 8'h00;
      latch_r    <= 8'h00;
      bus_req_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (trigger_s) begin
        page_r     <= cpu_wdata;
        src_page_r <= eff_page_s;
      end
      // A retrigger while busy restarts from byte 0 without releasing the bus
      if (trigger_s && busy_r) begin
        index_r <= 8'h00;
        state_r <= READ;
      end else begin
        case (state_r)
          IDLE: begin
            if (trigger_s) begin
              index_r   <= 8'h00;
              bus_req_r <= 1'b1;
              busy_r    <= 1'b1;
              state_r   <= REQ;
            end
          end
          REQ: begin
            if (bus_gnt) state_r <= READ;
          end
          READ: begin
            if (bus_gnt) state_r <= CAPT;
          end
          CAPT: begin
            latch_r <= m_rdata;
            state_r <= WRITE;
          end
          WRITE: begin
            if (bus_gnt) begin
              if (index_r == LAST_INDEX) begin
                bus_req_r <= 1'b0;
                busy_r    <= 1'b0;
                done_r    <= 1'b1;
                state_r   <= DONE;
              end else begin
                index_r <= index_r + 8'd1;
                state_r <= READ;
              end
            end
          end
          DONE: begin
            index_r <= 8'h00;
            if (trigger_s) begin
              bus_req_r <= 1'b1;
              busy_r    <= 1'b1;
              state_r   <= REQ;
            end else begin
              state_r <= IDLE;
            end
          end
          default: begin
            bus_req_r <= 1'b0;
            busy_r    <= 1'b0;
            state_r   <= IDLE;
          end
        endcase
      end
    end
  end

  // Register readback, zero for any non-matching read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rdata_r <= 8'h00;
    end else if (cpu_rd && (cpu_addr == DMA_REG_ADDR)) begin
      cpu_rdata_r <= page_r;
    end else begin
      cpu_rdata_r <= 8'h00;
    end
  end

  assign cpu_rdata = cpu_rdata_r;
  assign bus_req   = bus_req_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign m_rd      = rd_issue_s;
  assign m_wr      = wr_issue_s;
  assign m_addr    = m_addr_s;
  assign m_wdata   = m_wdata_s;

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: randomized and directed stimulus for oam_dma, checked every cycle against
// a transfer-level model (expected read/write queues and final OAM image).
module tb_oam_dma;
  localparam int LEN = 160;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [7:0]  cpu_rdata;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] m_addr;
  logic        m_rd;
  logic        m_wr;
  logic [7:0]  m_wdata;
  logic [7:0]  m_rdata;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int trig_cyc = 0;
  int done_cnt = 0;
  int done_rel = -1;
  int first_rd_rel = -1;
  logic [15:0] first_rd_addr = 16'h0000;
  int gnt_mode = 0;
  logic clr_oam = 1'b0;

  logic [15:0] rdq[$];
  logic [23:0] wq[$];
  logic [7:0]  oam[0:255];
  logic [7:0]  oam_exp[0:LEN-1];

  oam_dma dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_rdata(cpu_rdata),
    .bus_req(bus_req), .bus_gnt(bus_gnt),
    .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Source memory contents: byte i of page C0 is i^5A; other pages are distinguishable
  function automatic logic [7:0] mem_fn(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'hC0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Responder memory and OAM capture
  always @(posedge clk) begin
    if (m_rd) m_rdata <= mem_fn(m_addr);
    else      m_rdata <= 8'($urandom);
    if (clr_oam) begin
      for (int i = 0; i < 256; i++) oam[i] <= 8'h00;
    end else if (m_wr && m_addr[15:8] == 8'hFE) begin
      oam[m_addr[7:0]] <= m_wdata;
    end
  end

  // Arbiter: continuous grant, scheduled stalls, or random grant
  initial begin
    bus_gnt = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (gnt_mode)
        1: bus_gnt = !(((cyc - trig_cyc) >= 20 && (cyc - trig_cyc) <= 24) ||
                       ((cyc - trig_cyc) >= 69 && (cyc - trig_cyc) <= 75));
        2: bus_gnt = ($urandom_range(0, 3) != 0);
        default: bus_gnt = 1'b1;
      endcase
    end
  end

  // Per-cycle compare against the model queues
  always @(negedge clk) begin
    int rel;
    logic [23:0] wexp;
    rel = cyc - trig_cyc;
    if (reset === 1'b0) begin
      if (bus_gnt !== 1'b1) check("strobes_without_grant", {m_rd, m_wr}, 2'b00);
      if (gnt_mode == 1 && bus_gnt !== 1'b1) check("req_held_in_stall", bus_req, 1'b1);
      check("req_tracks_busy", bus_req, busy);
      if (m_rd) begin
        if (first_rd_rel < 0) begin
          first_rd_rel = rel;
          first_rd_addr = m_addr;
        end
        total++;
        if (rdq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_read: got addr %0h expected no read (cycle %0d)", m_addr, cyc);
        end else if (m_addr !== rdq[0]) begin
          bad++;
          $display("FAIL read_addr: got %0h expected %0h (cycle %0d)", m_addr, rdq[0], cyc);
          void'(rdq.pop_front());
        end else begin
          void'(rdq.pop_front());
        end
      end
      if (m_wr) begin
        total++;
        if (wq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got addr %0h expected no write (cycle %0d)", m_addr, cyc);
        end else begin
          wexp = wq.pop_front();
          if (m_addr !== wexp[23:8] || m_wdata !== wexp[7:0]) begin
            bad++;
            $display("FAIL write: got %0h/%0h expected %0h/%0h (cycle %0d)",
                     m_addr, m_wdata, wexp[23:8], wexp[7:0], cyc);
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_rel = rel;
        check("busy_falls_with_done", busy, 1'b0);
      end
    end
  end

  task automatic load_model(input logic [7:0] d);
    logic [7:0]  eff;
    logic [15:0] a;
    eff = (d >= 8'hE0) ? d - 8'h20 : d;
    rdq.delete();
    wq.delete();
    for (int i = 0; i < LEN; i++) begin
      a = {eff, 8'h00} + 16'(i);
      rdq.push_back(a);
      wq.push_back({16'hFE00 + 16'(i), mem_fn(a)});
      oam_exp[i] = mem_fn(a);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1;
    if (a == 16'hFF46) trig_cyc = cyc;
    @(posedge clk); #1;
    cpu_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    cpu_addr = a; cpu_rd = 1'b1;
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    d = cpu_rdata;
  endtask

  task automatic clear_oam();
    @(posedge clk); #1; clr_oam = 1'b1;
    @(posedge clk); #1; clr_oam = 1'b0;
  endtask

  // Fresh transfer: counters cleared, model loaded once the trigger cycle is past
  task automatic start(input logic [7:0] d);
    clear_oam();
    done_cnt = 0; done_rel = -1; first_rd_rel = -1;
    cpu_write(16'hFF46, d);
    load_model(d);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); n++;
    end
    if (done_cnt == 0) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag);
    int nerr;
    nerr = 0;
    for (int i = 0; i < LEN; i++) if (oam[i] !== oam_exp[i]) nerr++;
    check({tag, "_oam_bytes_wrong"}, nerr, 0);
    check({tag, "_queues_left"}, rdq.size() + wq.size(), 0);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_idle_after"}, {bus_req, busy, done}, 3'b000);
  endtask

  initial begin
    logic [7:0] rb;
    logic [7:0] pg;
    reset = 1'b1; cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_wr = 1'b0; cpu_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus_req, m_rd, m_wr, busy, done}, 5'b00000);
    check("reset_m_addr", m_addr, 16'h0000);
    check("reset_m_wdata", m_wdata, 8'h00);
    check("reset_cpu_rdata", cpu_rdata, 8'h00);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Basic copy from page C0 with continuous grant
    gnt_mode = 0;
    start(8'hC0);
    wait_done(1000);
    check("basic_first_rd_cycle", first_rd_rel, 2);
    check("basic_first_rd_addr", first_rd_addr, 16'hC000);
    check("basic_done_cycle", done_rel, 482);
    check("basic_oam_first", oam[0], 8'h5A);
    check("basic_oam_last", oam[159], 8'hC5);
    check_result("basic");

    // Readback of the raw page value and clamp of F1 to D1
    cpu_read(16'hFF46, rb);
    check("readback_c0", rb, 8'hC0);
    start(8'hF1);
    wait_done(1000);
    check("clamp_first_rd_addr", first_rd_addr, 16'hD100);
    check("clamp_done_cycle", done_rel, 482);
    check_result("clamp");
    cpu_read(16'hFF46, rb);
    check("readback_f1", rb, 8'hF1);

    // Non-matching register accesses
    cpu_write(16'hFF47, 8'hC0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("ff47_no_bus_req", {bus_req, busy}, 2'b00);
    end
    cpu_read(16'hFF47, rb);
    check("ff47_read_zero", rb, 8'h00);
    cpu_read(16'hFF46, rb);
    check("ff47_page_untouched", rb, 8'hF1);

    // Grant stalls: 5 cycles in a READ, 7 cycles in a WRITE
    gnt_mode = 1;
    start(8'hC0);
    wait_done(1000);
    check("stall_done_cycle", done_rel, 494);
    check_result("stall");
    gnt_mode = 0;

    // Retrigger with D0 while the write of index 40 is on the bus
    start(8'hC0);
    while (cyc - trig_cyc < 123) begin @(posedge clk); #1; end
    first_rd_rel = -1;
    cpu_write(16'hFF46, 8'hD0);
    load_model(8'hD0);
    wait_done(1000);
    check("retrig_first_rd_addr", first_rd_addr, 16'hD000);
    check("retrig_first_rd_cycle", first_rd_rel, 1);
    check("retrig_done_cycle", done_rel, 481);
    check("retrig_oam_first", oam[0], 8'h4A);
    check_result("retrig");

    // Random pages under random grant, with a mid-transfer readback
    gnt_mode = 2;
    for (int t = 0; t < 4; t++) begin
      pg = (t == 0) ? (8'hE0 | 8'($urandom_range(0, 31))) : 8'($urandom_range(0, 255));
      start(pg);
      repeat (30) @(posedge clk);
      cpu_read(16'hFF46, rb);
      check("rand_readback_busy", rb, pg);
      wait_done(3000);
      check_result("rand");
    end
    gnt_mode = 0;

    // Reset in the middle of a transfer
    start(8'hC0);
    while (cyc - trig_cyc < 100) begin @(posedge clk); #1; end
    #2; reset = 1'b1; #1;
    check("midreset_outputs", {bus_req, m_rd, m_wr, busy, done}, 5'b00000);
    @(posedge clk); #1;
    rdq.delete(); wq.delete();
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("midreset_no_done", done_cnt, 0);
    check("midreset_idle", {bus_req, busy}, 2'b00);
    check("midreset_cpu_rdata", cpu_rdata, 8'h00);
    cpu_read(16'hFF46, rb);
    check("midreset_page_cleared", rb, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
